p2s_stream: RTL and testbench

Parametrised AXI-Stream parallel-to-serial converter. It accepts N-bit words on a valid/ready slave port and emits them as N/W beats of W bits each on a valid/ready master port. A holding register lets the next word be accepted while the current word is still shifting, so sustained throughput is one beat per cycle with no bubble between words. It also supports selectable bit order and carries a per-word frame marker (`par_last`) through to the serial side. It sits between word-oriented producers and narrow serial links or lane muxes.

---
 rtl/p2s_stream_if.sv | 11 +
 rtl/p2s_stream.sv | 65 ++++++
 tb/tb_p2s_stream.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/p2s_stream_if.sv
// p2s_stream_if: valid/ready stream carrying a data word and a frame marker
interface p2s_stream_if #(
  parameter int DW = 8
);
  logic          valid;
  logic          ready;
  logic          last;
  logic [DW-1:0] data;
  modport master(output valid, data, last, input ready);
  modport slave(input valid, data, last, output ready);
endinterface

// File: rtl/p2s_stream.sv
// p2s_stream: parallel-to-serial stream converter with a holding register for bubble-free throughput
module p2s_stream #(
  parameter int N = 8,
  parameter int W = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic          clk,
  input logic          rst,
  p2s_stream_if.slave  par,
  p2s_stream_if.master ser
);
  localparam int BEATS = N / W;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
  localparam logic [1:0] EMPTY = 2'd0, SHIFT = 2'd1, FULL = 2'd2;
  if (N < 1 || W < 1 || N % W != 0) begin : g_bad_params
    $error("p2s_stream: W must be >= 1 and divide N");
  end
  logic [1:0]    state, state_nxt;
  logic [N-1:0]  sh, hd, sh_shift;
  logic          sh_last, hd_last;
  logic [CW-1:0] cnt;
  logic          acc, take, fin;
  assign par.ready = !rst && state != FULL;
  assign ser.valid = state != EMPTY;
  assign ser.data  = MSB_FIRST ? sh[N-1 -: W] : sh[W-1:0];
  assign ser.last  = ser.valid && cnt == LAST_CNT && sh_last;
  assign acc  = par.valid && par.ready;
  assign take = ser.valid && ser.ready;
  assign fin  = take && cnt == LAST_CNT;
  // next state and the shifted beat register; an accept overlapping a final beat reloads in place
  always_comb begin
    state_nxt = state == EMPTY ? (acc ? SHIFT : EMPTY)
              : state == SHIFT ? (fin && !acc ? EMPTY : acc && !fin ? FULL : SHIFT)
              : (fin ? SHIFT : FULL);
    sh_shift  = MSB_FIRST ? sh << W : sh >> W;
  end
  // state, beat counter, shift and hold registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      cnt     <= '0;
      sh      <= '0;
      sh_last <= 1'b0;
      hd      <= '0;
      hd_last <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= fin ? '0 : take ? cnt + 1'b1 : cnt;
      if (acc && (state == EMPTY || fin)) begin
        sh      <= par.data;
        sh_last <= par.last;
      end else if (fin && state == FULL) begin
        sh      <= hd;
        sh_last <= hd_last;
      end else if (take) begin
        sh <= sh_shift;
      end
      if (acc && state == SHIFT && !fin) begin
        hd      <= par.data;
        hd_last <= par.last;
      end
    end
  end
endmodule

// File: tb/tb_p2s_stream.sv
// tb_p2s_stream: two converter configurations checked against a queue-of-beats reference model
module tb_p2s_stream;
  typedef struct {
    logic [3:0] d;
    logic       l;
  } beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  p2s_stream_if #(.DW(8))  pa ();
  p2s_stream_if #(.DW(1))  sa ();
  p2s_stream_if #(.DW(16)) pb ();
  p2s_stream_if #(.DW(4))  sb ();
  p2s_stream #(.N(8), .W(1), .MSB_FIRST(1'b0)) dut_a (.clk(clk), .rst(rst), .par(pa), .ser(sa));
  p2s_stream #(.N(16), .W(4), .MSB_FIRST(1'b1)) dut_b (.clk(clk), .rst(rst), .par(pb), .ser(sb));
  beat_t qa[$];
  beat_t qb[$];
  int n_chk = 0;
  int n_err = 0;
  bit acc_a_g, acc_b_g;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push_a(input logic [7:0] w, input logic l);
    beat_t b;
    for (int i = 0; i < 8; i++) begin
      b.d = 4'(w[i]);
      b.l = l && i == 7;
      qa.push_back(b);
    end
  endtask
  task automatic push_b(input logic [15:0] w, input logic l);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.d = 4'(w >> (12 - 4 * i));
      b.l = l && i == 3;
      qb.push_back(b);
    end
  endtask
  task automatic step();
    logic tk_a, tk_b, la, lb;
    logic [7:0] da;
    logic [15:0] db;
    #1;
    chk("a_ready", 32'(pa.ready), 32'(!rst && qa.size() <= 8));
    chk("a_valid", 32'(sa.valid), 32'(qa.size() != 0));
    if (qa.size() != 0) begin
      chk("a_data", 32'(sa.data), 32'(qa[0].d));
      chk("a_last", 32'(sa.last), 32'(qa[0].l));
    end else chk("a_last_idle", 32'(sa.last), 0);
    chk("b_ready", 32'(pb.ready), 32'(!rst && qb.size() <= 4));
    chk("b_valid", 32'(sb.valid), 32'(qb.size() != 0));
    if (qb.size() != 0) begin
      chk("b_data", 32'(sb.data), 32'(qb[0].d));
      chk("b_last", 32'(sb.last), 32'(qb[0].l));
    end else chk("b_last_idle", 32'(sb.last), 0);
    acc_a_g = pa.valid && pa.ready;
    acc_b_g = pb.valid && pb.ready;
    tk_a = sa.valid && sa.ready;
    tk_b = sb.valid && sb.ready;
    da = pa.data;
    la = pa.last;
    db = pb.data;
    lb = pb.last;
    @(posedge clk);
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (tk_a && qa.size() != 0) void'(qa.pop_front());
      if (tk_b && qb.size() != 0) void'(qb.pop_front());
      if (acc_a_g) push_a(da, la);
      if (acc_b_g) push_b(db, lb);
    end
    #1;
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic send_a(input logic [7:0] d, input logic l);
    int n = 0;
    pa.valid = 1'b1;
    pa.data  = d;
    pa.last  = l;
    do begin
      step();
      n++;
    end while (!acc_a_g && n < 40);
    chk("a_accept", 32'(acc_a_g), 1);
  endtask
  task automatic send_b(input logic [15:0] d, input logic l);
    int n = 0;
    pb.valid = 1'b1;
    pb.data  = d;
    pb.last  = l;
    do begin
      step();
      n++;
    end while (!acc_b_g && n < 40);
    chk("b_accept", 32'(acc_b_g), 1);
  endtask
  initial begin
    pa.valid = 1'b1;
    pa.data  = 8'hFF;
    pa.last  = 1'b0;
    sa.ready = 1'b1;
    pb.valid = 1'b1;
    pb.data  = 16'hFFFF;
    pb.last  = 1'b0;
    sb.ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_a_data", 32'(sa.data), 0);
    chk("rst_b_data", 32'(sb.data), 0);
    run(2);
    chk("rst_a_data_held", 32'(sa.data), 0);
    rst = 1'b0;
    pa.valid = 1'b0;
    pb.valid = 1'b0;
    run(1);
    send_a(8'hA5, 1'b0);
    pa.valid = 1'b0;
    chk("latency_valid", 32'(sa.valid), 1);
    chk("latency_bit0", 32'(sa.data), 1);
    run(10);
    send_a(8'h3C, 1'b0);
    send_a(8'hC3, 1'b0);
    pa.valid = 1'b0;
    run(18);
    send_a(8'hA5, 1'b0);
    pa.valid = 1'b0;
    run(2);
    sa.ready = 1'b0;
    run(3);
    chk("bp_hold_bit2", 32'(sa.data), 1);
    chk("bp_hold_valid", 32'(sa.valid), 1);
    sa.ready = 1'b1;
    run(8);
    send_b(16'h1234, 1'b1);
    send_b(16'hABCD, 1'b0);
    pb.valid = 1'b0;
    run(12);
    send_a(8'hA5, 1'b0);
    send_a(8'h5A, 1'b0);
    pa.valid = 1'b0;
    run(2);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(sa.valid), 0);
    rst = 1'b0;
    send_a(8'h0F, 1'b0);
    pa.valid = 1'b0;
    run(10);
    repeat (600) begin
      rst      = ($urandom_range(0, 99) == 0);
      pa.valid = 1'($urandom);
      pa.data  = 8'($urandom);
      pa.last  = 1'($urandom);
      sa.ready = ($urandom_range(0, 3) != 0);
      pb.valid = 1'($urandom);
      pb.data  = 16'($urandom);
      pb.last  = 1'($urandom);
      sb.ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;
    pa.valid = 1'b0;
    pb.valid = 1'b0;
    sa.ready = 1'b1;
    sb.ready = 1'b1;
    run(40);
    chk("drain_a", 32'(sa.valid), 0);
    chk("drain_b", 32'(sb.valid), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
